decode_seq: RTL and testbench



---
 rtl/rissy_isa_pkg.sv | 40 ++++
 rtl/imm_gen.sv | 30 +++
 rtl/decode_seq.sv | 218 +++++++++++++++++++++
 tb/tb_decode_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rissy_isa_pkg.sv
// Rissy ISA constants shared by the decoder/sequencer: opcodes, ALU ops,
// decoder states and instruction field positions.
package rissy_isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_NDU = 4'h2,
        OP_LW  = 4'h4,
        OP_SW  = 4'h5,
        OP_JAL = 4'h8,
        OP_BEQ = 4'hC
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_NAND  = 3'b001,
        ALU_CMP   = 3'b010,
        ALU_PCREL = 3'b011,
        ALU_ADDR  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        DEC,
        BEQ_CHK,
        BEQ_TAKE,
        JAL_JMP
    } dec_state_e;

    localparam int unsigned OP_HI   = 15;
    localparam int unsigned OP_LO   = 12;
    localparam int unsigned RA_HI   = 11;
    localparam int unsigned RA_LO   = 9;
    localparam int unsigned RB_HI   = 8;
    localparam int unsigned RB_LO   = 6;
    localparam int unsigned RC_HI   = 5;
    localparam int unsigned RC_LO   = 3;
    localparam int unsigned OFF6_HI = 5;
    localparam int unsigned OFF9_HI = 8;

endpackage

// File: rtl/imm_gen.sv
// Offset extraction and PC_STEP compensation for the Rissy decoder.
// DEC_SEXT_EN: sign-extend 6/9-bit offsets; undefined gives zero-extension.
module imm_gen
    import rissy_isa_pkg::*;
#(
    parameter int unsigned XLEN    = 16,
    parameter int unsigned PC_STEP = 2
) (
    input  logic [OFF9_HI:0] off_i,
    output logic [XLEN-1:0]  off6_o,
    output logic [XLEN-1:0]  off6_pc_o,
    output logic [XLEN-1:0]  off9_pc_o
);

    logic [XLEN-1:0] off9;

    always_comb begin
`ifdef DEC_SEXT_EN
        off6_o = {{(XLEN-OFF6_HI-1){off_i[OFF6_HI]}}, off_i[OFF6_HI:0]};
        off9   = {{(XLEN-OFF9_HI-1){off_i[OFF9_HI]}}, off_i};
`else
        off6_o = {{(XLEN-OFF6_HI-1){1'b0}}, off_i[OFF6_HI:0]};
        off9   = {{(XLEN-OFF9_HI-1){1'b0}}, off_i};
`endif
        // Targets are relative to the already-incremented PC, so pull back one step.
        off6_pc_o = off6_o - XLEN'(PC_STEP);
        off9_pc_o = off9 - XLEN'(PC_STEP);
    end

endmodule

// File: rtl/decode_seq.sv
// Registered Rissy instruction decoder/sequencer with valid/ready intake and
// internal BEQ/JAL sequencing. Offset extension selected by DEC_SEXT_EN (see imm_gen).
module decode_seq
    import rissy_isa_pkg::*;
#(
    parameter int unsigned XLEN    = 16,
    parameter int unsigned RADDR_W = 3,
    parameter int unsigned PC_REG  = 7,
    parameter int unsigned PC_STEP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid,
    input  logic [XLEN-1:0]    inst,
    output logic               inst_ready,
    input  logic [1:0]         flags,
    input  logic               exec_stall,
    output logic               ctrl_valid,
    output logic               w_en,
    output logic               load_store,
    output logic               mem_en,
    output logic [2:0]         alu_op,
    output logic [RADDR_W-1:0] ra_add,
    output logic [RADDR_W-1:0] rb_add,
    output logic [RADDR_W-1:0] write_add,
    output logic [XLEN-1:0]    immediate,
    output logic               pc_inc,
    output logic               illegal,
    output logic               busy
);

    localparam logic [RADDR_W-1:0] PC_ADDR = RADDR_W'(PC_REG);

    dec_state_e         state_q, state_d;
    logic [OFF9_HI:0]   inst_off_q, inst_off_d;
    logic               ctrl_valid_q, ctrl_valid_d;
    logic               w_en_q, w_en_d;
    logic               load_store_q, load_store_d;
    logic               mem_en_q, mem_en_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [RADDR_W-1:0] ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic               pc_inc_q, pc_inc_d;
    logic               illegal_q, illegal_d;

    logic               accept;
    logic [3:0]         opcode;
    logic [OFF9_HI:0]   off_src;
    logic [XLEN-1:0]    off6, off6_pc, off9_pc;
    logic               unused_carry;

    assign unused_carry = flags[1];
    assign inst_ready   = (state_q == DEC) && !exec_stall && !rst;
    assign accept       = inst_valid && inst_ready;
    assign opcode       = inst[OP_HI:OP_LO];
    // LW decodes from the live word; BEQ/JAL targets come from the latch.
    assign off_src      = (state_q == DEC) ? inst[OFF9_HI:0] : inst_off_q;

    imm_gen #(
        .XLEN    (XLEN),
        .PC_STEP (PC_STEP)
    ) u_imm_gen (
        .off_i     (off_src),
        .off6_o    (off6),
        .off6_pc_o (off6_pc),
        .off9_pc_o (off9_pc)
    );

    always_comb begin
        state_d      = state_q;
        inst_off_d   = inst_off_q;
        ctrl_valid_d = ctrl_valid_q;
        w_en_d       = w_en_q;
        load_store_d = load_store_q;
        mem_en_d     = mem_en_q;
        alu_op_d     = alu_op_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        wa_d         = wa_q;
        imm_d        = imm_q;
        pc_inc_d     = pc_inc_q;
        illegal_d    = illegal_q;

        if (!exec_stall) begin
            ctrl_valid_d = 1'b0;
            w_en_d       = 1'b0;
            load_store_d = 1'b0;
            mem_en_d     = 1'b0;
            alu_op_d     = '0;
            ra_d         = '0;
            rb_d         = '0;
            wa_d         = '0;
            imm_d        = '0;
            pc_inc_d     = 1'b0;
            illegal_d    = 1'b0;

            case (state_q)
                DEC: begin
                    if (accept) begin
                        inst_off_d   = inst[OFF9_HI:0];
                        ctrl_valid_d = 1'b1;
                        case (opcode)
                            OP_ADD, OP_NDU: begin
                                alu_op_d = (opcode == OP_ADD) ? ALU_ADD : ALU_NAND;
                                ra_d     = RADDR_W'(inst[RA_HI:RA_LO]);
                                rb_d     = RADDR_W'(inst[RB_HI:RB_LO]);
                                wa_d     = RADDR_W'(inst[RC_HI:RC_LO]);
                                w_en_d   = 1'b1;
                                pc_inc_d = 1'b1;
                            end
                            OP_LW: begin
                                alu_op_d     = ALU_ADDR;
                                rb_d         = RADDR_W'(inst[RB_HI:RB_LO]);
                                wa_d         = RADDR_W'(inst[RA_HI:RA_LO]);
                                w_en_d       = 1'b1;
                                mem_en_d     = 1'b1;
                                load_store_d = 1'b1;
                                imm_d        = off6;
                                pc_inc_d     = 1'b1;
                            end
                            OP_SW: begin
                                alu_op_d = ALU_ADDR;
                                ra_d     = RADDR_W'(inst[RA_HI:RA_LO]);
                                rb_d     = RADDR_W'(inst[RB_HI:RB_LO]);
                                mem_en_d = 1'b1;
                                imm_d    = off6;
                                pc_inc_d = 1'b1;
                            end
                            OP_BEQ: begin
                                alu_op_d = ALU_CMP;
                                ra_d     = RADDR_W'(inst[RA_HI:RA_LO]);
                                rb_d     = RADDR_W'(inst[RB_HI:RB_LO]);
                                state_d  = BEQ_CHK;
                            end
                            OP_JAL: begin
                                alu_op_d = ALU_PCREL;
                                rb_d     = PC_ADDR;
                                wa_d     = RADDR_W'(inst[RA_HI:RA_LO]);
                                w_en_d   = 1'b1;
                                imm_d    = XLEN'(PC_STEP);
                                state_d  = JAL_JMP;
                            end
                            default: begin
                                pc_inc_d  = 1'b1;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                end
                BEQ_CHK: begin
                    if (flags[0]) begin
                        state_d = BEQ_TAKE;
                    end else begin
                        pc_inc_d = 1'b1;
                        state_d  = DEC;
                    end
                end
                BEQ_TAKE, JAL_JMP: begin
                    ctrl_valid_d = 1'b1;
                    alu_op_d     = ALU_PCREL;
                    rb_d         = PC_ADDR;
                    wa_d         = PC_ADDR;
                    w_en_d       = 1'b1;
                    imm_d        = (state_q == BEQ_TAKE) ? off6_pc : off9_pc;
                    pc_inc_d     = 1'b1;
                    state_d      = DEC;
                end
                default: state_d = DEC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DEC;
            inst_off_q   <= '0;
            ctrl_valid_q <= 1'b0;
            w_en_q       <= 1'b0;
            load_store_q <= 1'b0;
            mem_en_q     <= 1'b0;
            alu_op_q     <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            wa_q         <= '0;
            imm_q        <= '0;
            pc_inc_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_off_q   <= inst_off_d;
            ctrl_valid_q <= ctrl_valid_d;
            w_en_q       <= w_en_d;
            load_store_q <= load_store_d;
            mem_en_q     <= mem_en_d;
            alu_op_q     <= alu_op_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            wa_q         <= wa_d;
            imm_q        <= imm_d;
            pc_inc_q     <= pc_inc_d;
            illegal_q    <= illegal_d;
        end
    end

    assign ctrl_valid = ctrl_valid_q;
    assign w_en       = w_en_q;
    assign load_store = load_store_q;
    assign mem_en     = mem_en_q;
    assign alu_op     = alu_op_q;
    assign ra_add     = ra_q;
    assign rb_add     = rb_q;
    assign write_add  = wa_q;
    assign immediate  = imm_q;
    assign pc_inc     = pc_inc_q;
    assign illegal    = illegal_q;
    assign busy       = (state_q != DEC);

endmodule

// File: tb/tb_decode_seq.sv
// Directed self-checking bench for decode_seq; expectations follow DEC_SEXT_EN.
module tb_decode_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_ready;
    logic [1:0]  flags;
    logic        exec_stall;
    logic        ctrl_valid, w_en, load_store, mem_en, pc_inc, illegal, busy;
    logic [2:0]  alu_op, ra_add, rb_add, write_add;
    logic [15:0] immediate;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    decode_seq #(
        .XLEN    (16),
        .RADDR_W (3),
        .PC_REG  (7),
        .PC_STEP (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_ready (inst_ready),
        .flags      (flags),
        .exec_stall (exec_stall),
        .ctrl_valid (ctrl_valid),
        .w_en       (w_en),
        .load_store (load_store),
        .mem_en     (mem_en),
        .alu_op     (alu_op),
        .ra_add     (ra_add),
        .rb_add     (rb_add),
        .write_add  (write_add),
        .immediate  (immediate),
        .pc_inc     (pc_inc),
        .illegal    (illegal),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        inst       = w;
        inst_valid = 1'b1;
        check("ready_before_accept", 32'(inst_ready), 1);
        tick();
        inst_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lw_imm;
`ifdef DEC_SEXT_EN
        lw_imm = 16'hFFFF;
`else
        lw_imm = 16'h003F;
`endif
        rst = 1'b1; inst_valid = 1'b0; inst = '0; flags = 2'b00; exec_stall = 1'b0;
        tick(); tick();
        check("rst_ctrl_valid", 32'(ctrl_valid), 0);
        check("rst_pc_inc", 32'(pc_inc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready_in_rst", 32'(inst_ready), 0);
        rst = 1'b0;
        #1;
        check("rst_ready_after", 32'(inst_ready), 1);
        check("rst_imm", 32'(immediate), 0);

        // ADD then back-to-back NDU
        inst = 16'h0298; inst_valid = 1'b1;
        tick();
        check("add_cv", 32'(ctrl_valid), 1);
        check("add_ra", 32'(ra_add), 1);
        check("add_rb", 32'(rb_add), 2);
        check("add_wa", 32'(write_add), 3);
        check("add_alu", 32'(alu_op), 0);
        check("add_wen", 32'(w_en), 1);
        check("add_pcinc", 32'(pc_inc), 1);
        check("add_imm", 32'(immediate), 0);
        check("add_mem", 32'(mem_en), 0);
        check("b2b_ready", 32'(inst_ready), 1);
        inst = 16'h2298;
        tick();
        inst_valid = 1'b0;
        check("ndu_cv", 32'(ctrl_valid), 1);
        check("ndu_alu", 32'(alu_op), 1);
        check("ndu_pcinc", 32'(pc_inc), 1);
        tick();
        check("idle_cv", 32'(ctrl_valid), 0);
        check("idle_pcinc", 32'(pc_inc), 0);

        // BEQ taken
        flags = 2'b01;
        send(16'hC285);
        check("beqt_cv", 32'(ctrl_valid), 1);
        check("beqt_alu", 32'(alu_op), 2);
        check("beqt_ra", 32'(ra_add), 1);
        check("beqt_rb", 32'(rb_add), 2);
        check("beqt_wen", 32'(w_en), 0);
        check("beqt_pcinc0", 32'(pc_inc), 0);
        check("beqt_ready1", 32'(inst_ready), 0);
        check("beqt_busy1", 32'(busy), 1);
        tick();
        check("beqt_gap_cv", 32'(ctrl_valid), 0);
        check("beqt_gap_pcinc", 32'(pc_inc), 0);
        check("beqt_ready2", 32'(inst_ready), 0);
        tick();
        check("beqt_cv2", 32'(ctrl_valid), 1);
        check("beqt_wa", 32'(write_add), 7);
        check("beqt_rb2", 32'(rb_add), 7);
        check("beqt_alu2", 32'(alu_op), 3);
        check("beqt_wen2", 32'(w_en), 1);
        check("beqt_imm", 32'(immediate), 32'h0003);
        check("beqt_pcinc", 32'(pc_inc), 1);
        check("beqt_ready3", 32'(inst_ready), 1);
        tick();
        check("beqt_pcinc_once", 32'(pc_inc), 0);

        // BEQ not taken
        flags = 2'b00;
        send(16'hC285);
        check("beqn_alu", 32'(alu_op), 2);
        tick();
        check("beqn_cv", 32'(ctrl_valid), 0);
        check("beqn_pcinc", 32'(pc_inc), 1);
        check("beqn_wen", 32'(w_en), 0);
        check("beqn_busy", 32'(busy), 0);
        check("beqn_ready", 32'(inst_ready), 1);

        // BEQ taken with zero offset wraps
        flags = 2'b01;
        send(16'hC000);
        tick(); tick();
        check("beq0_imm_wrap", 32'(immediate), 32'hFFFE);

        // JAL
        send(16'h8A10);
        check("jal1_wa", 32'(write_add), 5);
        check("jal1_rb", 32'(rb_add), 7);
        check("jal1_imm", 32'(immediate), 2);
        check("jal1_pcinc", 32'(pc_inc), 0);
        check("jal1_wen", 32'(w_en), 1);
        tick();
        check("jal2_wa", 32'(write_add), 7);
        check("jal2_imm", 32'(immediate), 32'h000E);
        check("jal2_pcinc", 32'(pc_inc), 1);

        // LW / SW
        send(16'h47FF);
        check("lw_wa", 32'(write_add), 3);
        check("lw_rb", 32'(rb_add), 7);
        check("lw_ra", 32'(ra_add), 0);
        check("lw_ls", 32'(load_store), 1);
        check("lw_mem", 32'(mem_en), 1);
        check("lw_alu", 32'(alu_op), 7);
        check("lw_imm", 32'(immediate), 32'(lw_imm));
        send(16'h5A45);
        check("sw_ra", 32'(ra_add), 5);
        check("sw_rb", 32'(rb_add), 1);
        check("sw_wa", 32'(write_add), 0);
        check("sw_wen", 32'(w_en), 0);
        check("sw_ls", 32'(load_store), 0);
        check("sw_mem", 32'(mem_en), 1);
        check("sw_imm", 32'(immediate), 5);

        // Undefined opcode
        send(16'hF123);
        check("ill_cv", 32'(ctrl_valid), 1);
        check("ill_flag", 32'(illegal), 1);
        check("ill_pcinc", 32'(pc_inc), 1);
        check("ill_fields", 32'({ra_add, rb_add, write_add, w_en, mem_en, alu_op}), 0);
        check("ill_imm", 32'(immediate), 0);
        tick();
        check("ill_pulse", 32'(illegal), 0);

        // Reset mid-JAL
        send(16'h8A10);
        check("rjal_wa", 32'(write_add), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rjal_cv", 32'(ctrl_valid), 0);
        check("rjal_pcinc", 32'(pc_inc), 0);
        check("rjal_busy", 32'(busy), 0);
        check("rjal_ready", 32'(inst_ready), 1);
        tick();
        check("rjal_no_word2", 32'(ctrl_valid), 0);

        // Stall mid-BEQ: flags ignored while stalled, pc_inc held not repeated
        flags = 2'b01;
        send(16'hC285);
        exec_stall = 1'b1; flags = 2'b00;
        #1;
        check("stall_ready", 32'(inst_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_cv", 32'(ctrl_valid), 1);
            check("stall_hold_busy", 32'(busy), 1);
        end
        exec_stall = 1'b0; flags = 2'b01;
        tick();
        check("stall_gap_cv", 32'(ctrl_valid), 0);
        check("stall_gap_busy", 32'(busy), 1);
        tick();
        check("stall_take_pcinc", 32'(pc_inc), 1);
        check("stall_take_imm", 32'(immediate), 3);
        exec_stall = 1'b1;
        tick();
        check("stall_pcinc_held", 32'(pc_inc), 1);
        exec_stall = 1'b0;
        tick();
        check("stall_pcinc_done", 32'(pc_inc), 0);
        check("stall_cv_done", 32'(ctrl_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
